// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the 1:N stream demultiplexer.
package demux_stream_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StUcast = 2'd1,
        StBcast = 2'd2
    } demux_state_e;

    localparam int unsigned ErrCntW = 8;

    // Unicast codes 0..n-1 plus one broadcast code.
    function automatic int unsigned sel_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/demux_bcast_tracker.sv
// Done-mask tracker for broadcast beats: per-channel valid and completion flag.
module demux_bcast_tracker #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         active_i,
    input  logic [N-1:0] ready_i,
    output logic [N-1:0] valid_o,
    output logic         complete_o
);

    logic [N-1:0] done_q, done_d;
    logic [N-1:0] served;

    always_comb begin
        served     = done_q | ready_i;
        complete_o = active_i & (&served);
        valid_o    = active_i ? ~done_q : '0;
        done_d     = done_q;
        if (complete_o) begin
            done_d = '0;
        end else if (active_i) begin
            done_d = served;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1:N stream demux with unicast/broadcast select and valid/ready handshake.
// Optional error counters enabled with `define DEMUX_STREAM_ERR_EN.
module demux_stream_1ton
    import demux_stream_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 2,
    parameter int unsigned SW = sel_w(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic [SW-1:0]       in_sel,
    output logic [N-1:0]        out_valid,
    input  logic [N-1:0]        out_ready,
    output logic [DW-1:0]       out_data,
    output logic                busy
`ifdef DEMUX_STREAM_ERR_EN
    ,
    output logic [ErrCntW-1:0]  err_cnt,
    output logic                err_sticky
`endif
);

    demux_state_e  state_q, state_d;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] data_q;
    logic [N-1:0]  ucast_mask;
    logic [N-1:0]  bcast_valid;
    logic          bcast_complete;
    logic          ucast_done;
    logic          complete;
    logic          accept;

    demux_bcast_tracker #(
        .N(N)
    ) u_tracker (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .active_i   (state_q == StBcast),
        .ready_i    (out_ready),
        .valid_o    (bcast_valid),
        .complete_o (bcast_complete)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ucast_mask[i] = (state_q == StUcast) && (sel_q == SW'(i));
        end
        ucast_done = |(ucast_mask & out_ready);
        complete   = ucast_done | bcast_complete;
        in_ready   = (state_q == StEmpty) | complete;
        accept     = in_valid & in_ready;
        out_valid  = ucast_mask | bcast_valid;
        out_data   = data_q;
        busy       = (state_q != StEmpty);
    end

    // A new accept decides the next state; otherwise completion empties the holder.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_sel < SW'(N)) begin
                state_d = StUcast;
            end else if (in_sel == SW'(N)) begin
                state_d = StBcast;
            end else begin
                state_d = StEmpty;
            end
        end else if (complete) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sel_q  <= in_sel;
                data_q <= in_data;
            end
        end
    end

`ifdef DEMUX_STREAM_ERR_EN
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
    logic               err_sticky_q, err_sticky_d;
    logic               bad_beat;

    always_comb begin
        bad_beat     = accept && (in_sel > SW'(N));
        err_cnt_d    = (bad_beat && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
        err_sticky_d = err_sticky_q | bad_beat;
        err_cnt      = err_cnt_q;
        err_sticky   = err_sticky_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed self-checking bench for demux_stream_1ton at DW=8, N=4.
module tb_demux_stream_1ton;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
`ifdef DEMUX_STREAM_ERR_EN
    logic [7:0]    err_cnt;
    logic          err_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt [N];
    int hs_base [N];

    demux_stream_1ton #(
        .DW(DW),
        .N (N),
        .SW(SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef DEMUX_STREAM_ERR_EN
        ,
        .err_cnt   (err_cnt),
        .err_sticky(err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel handshake counter, checked around the broadcast test.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (out_valid[i] && out_ready[i]) hs_cnt[i] = hs_cnt[i] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) hs_cnt[i] = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_data",  32'(out_data),  32'h0);
        check_eq("rst_busy",      32'(busy),      32'h0);
        check_eq("rst_in_ready",  32'(in_ready),  32'h1);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Unicast streaming to channel 2.
        in_valid = 1'b1; in_sel = 3'd2; in_data = 8'hA5; out_ready = 4'b0100;
        #1 check_eq("uc_in_ready0", 32'(in_ready), 32'h1);
        tick();
        check_eq("uc_valid0", 32'(out_valid), 32'h4);
        check_eq("uc_data0",  32'(out_data),  32'hA5);
        in_data = 8'h5A;
        #1 check_eq("uc_in_ready1", 32'(in_ready), 32'h1);
        tick();
        check_eq("uc_valid1", 32'(out_valid), 32'h4);
        check_eq("uc_data1",  32'(out_data),  32'h5A);
        in_valid = 1'b0;
        tick();
        check_eq("uc_idle", 32'(out_valid), 32'h0);

        // Backpressure on channel 1.
        in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h3C; out_ready = 4'b0000;
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("bp_valid",    32'(out_valid), 32'h2);
            check_eq("bp_data",     32'(out_data),  32'h3C);
            check_eq("bp_in_ready", 32'(in_ready),  32'h0);
            if (c < 2) tick();
        end
        out_ready = 4'b0010;
        #1 check_eq("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        check_eq("bp_done", 32'(out_valid), 32'h0);

        // Broadcast with staggered readiness.
        for (int i = 0; i < N; i++) hs_base[i] = hs_cnt[i];
        in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h77; out_ready = 4'b0000;
        tick();
        in_valid = 1'b0;
        check_eq("bc_valid0", 32'(out_valid), 32'hF);
        check_eq("bc_data",   32'(out_data),  32'h77);
        out_ready = 4'b0001;
        #1 check_eq("bc_in_ready0", 32'(in_ready), 32'h0);
        tick();
        check_eq("bc_valid1", 32'(out_valid), 32'hE);
        out_ready = 4'b0110;
        tick();
        check_eq("bc_valid2", 32'(out_valid), 32'h8);
        out_ready = 4'b1000;
        #1 check_eq("bc_in_ready_last", 32'(in_ready), 32'h1);
        tick();
        check_eq("bc_valid3", 32'(out_valid), 32'h0);
        check_eq("bc_busy",   32'(busy),      32'h0);
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("bc_once_ch%0d", i), 32'(hs_cnt[i] - hs_base[i]), 32'h1);
        end

        // Invalid select is consumed and dropped.
        in_valid = 1'b1; in_sel = 3'd5; in_data = 8'hFF; out_ready = 4'b1111;
        #1 check_eq("inv_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check_eq("inv_valid", 32'(out_valid), 32'h0);
        check_eq("inv_busy",  32'(busy),      32'h0);
`ifdef DEMUX_STREAM_ERR_EN
        check_eq("err_cnt1",    32'(err_cnt),    32'h1);
        check_eq("err_sticky1", 32'(err_sticky), 32'h1);
        in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        check_eq("err_cnt_sat", 32'(err_cnt), 32'hFF);
        tick();
`endif

        // Broadcast completes while a new unicast beat is accepted.
        in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h22; out_ready = 4'b0000;
        tick();
        in_sel = 3'd0; in_data = 8'h11; out_ready = 4'b1111;
        #1 check_eq("cn_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        check_eq("cn_valid", 32'(out_valid), 32'h1);
        check_eq("cn_data",  32'(out_data),  32'h11);
        out_ready = 4'b0001;
        tick();
        check_eq("cn_drain", 32'(out_valid), 32'h0);

        // Reset in the middle of a broadcast with two channels served.
        in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h33; out_ready = 4'b0000;
        tick();
        in_valid = 1'b0; out_ready = 4'b0011;
        tick();
        out_ready = 4'b0000;
        check_eq("mr_partial", 32'(out_valid), 32'hC);
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid",    32'(out_valid), 32'h0);
        check_eq("mr_busy",     32'(busy),      32'h0);
        check_eq("mr_in_ready", 32'(in_ready),  32'h1);
        check_eq("mr_data",     32'(out_data),  32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h44;
        tick();
        in_valid = 1'b0;
        check_eq("mr_fresh_bcast", 32'(out_valid), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
